// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions/xRET against machine interrupts, then flushes, redirects and stalls until fetch restarts.
// Optional redirect watchdog enabled by defining TRAP_CTRL_WATCHDOG_EN (adds parameter WDT_CYCLES and port wdt_fire_o).
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 3
`ifdef TRAP_CTRL_WATCHDOG_EN
  ,
  parameter int WDT_CYCLES   = 64
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_target_i,
  input  logic        wb_valid_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic [31:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic        fetch_ack_i,
  output logic        int_take_o,
  output logic [31:0] int_cause_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
`ifdef TRAP_CTRL_WATCHDOG_EN
  output logic        wdt_fire_o,
`endif
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INT_PEND = 3'd1,
    FLUSH    = 3'd2,
    REDIRECT = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [3:0]  r_flush_cnt;
  logic [31:0] r_target;
  logic        r_int_take;
  logic [31:0] r_int_cause;
  logic        w_capture;
  logic        w_take;
  logic        w_wdt_timeout;
  logic        w_mei;
  logic        w_msi;
  logic        w_mti;
  logic [31:0] w_cause;
  logic        w_unused;

  // Synchronizer bit order: {meip, mtip, msip}
  assign w_mei = r_sync2[2] & mie_i[11] & mstatus_mie_i;
  assign w_mti = r_sync2[1] & mie_i[7]  & mstatus_mie_i;
  assign w_msi = r_sync2[0] & mie_i[3]  & mstatus_mie_i;
  assign w_cause = w_mei ? 32'h8000_000B :
                   w_msi ? 32'h8000_0003 : 32'h8000_0007;
  assign w_unused = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

`ifdef TRAP_CTRL_WATCHDOG_EN
  logic [7:0] r_wdt_cnt;
  logic       r_wdt_fire;
  assign wdt_fire_o = r_wdt_fire;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_take        = 1'b0;
    w_wdt_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        // Exceptions take precedence over a same-cycle eligible interrupt.
        if (exc_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = FLUSH;
        end else if (wb_valid_i && (w_mei || w_msi || w_mti)) begin
          w_take      = 1'b1;
          w_state_nxt = INT_PEND;
        end
      end
      INT_PEND: begin
        if (exc_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == 4'd0) w_state_nxt = REDIRECT;
      end
      REDIRECT: w_state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (fetch_ack_i) begin
          w_state_nxt = IDLE;
        end
`ifdef TRAP_CTRL_WATCHDOG_EN
        else if (r_wdt_cnt == 8'(WDT_CYCLES - 1)) begin
          w_wdt_timeout = 1'b1;
          w_state_nxt   = REDIRECT;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_sync1     <= 3'b000;
      r_sync2     <= 3'b000;
      r_flush_cnt <= 4'd0;
      r_target    <= 32'd0;
      r_int_take  <= 1'b0;
      r_int_cause <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync1    <= {xint_meip_i, xint_mtip_i, xint_msip_i};
      r_sync2    <= r_sync1;
      r_int_take <= w_take;
      if (w_take) r_int_cause <= w_cause;
      if (w_capture) begin
        r_target    <= exc_target_i;
        r_flush_cnt <= 4'(FLUSH_CYCLES - 1);
      end else if (r_state == FLUSH && r_flush_cnt != 4'd0) begin
        r_flush_cnt <= r_flush_cnt - 4'd1;
      end
    end
  end

`ifdef TRAP_CTRL_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdt_cnt  <= 8'd0;
      r_wdt_fire <= 1'b0;
    end else begin
      r_wdt_fire <= w_wdt_timeout;
      if (r_state != WAIT_ACK || w_wdt_timeout) r_wdt_cnt <= 8'd0;
      else                                      r_wdt_cnt <= r_wdt_cnt + 8'd1;
    end
  end
`endif

  // Every non-IDLE state holds the pipeline, so stall and busy coincide.
  assign int_take_o    = r_int_take;
  assign int_cause_o   = r_int_cause;
  assign flush_o       = (r_state == FLUSH);
  assign pc_redirect_o = (r_state == REDIRECT);
  assign pc_target_o   = (r_state == IDLE) ? 32'd0 : r_target;
  assign stall_o       = (r_state != IDLE);
  assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception flow, interrupt priority/masking, exception-vs-interrupt, reset abort, watchdog.
module tb_trap_ctrl;

  localparam int FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        wb_valid;
  logic        meip, mtip, msip;
  logic [31:0] mie;
  logic        mstatus_mie;
  logic        fetch_ack;
  logic        int_take;
  logic [31:0] int_cause;
  logic        flush, stall, redirect, busy;
  logic [31:0] target;
`ifdef TRAP_CTRL_WATCHDOG_EN
  logic        wdt_fire;
`endif

  int n_checks = 0;
  int n_errors = 0;

  trap_ctrl #(
    .FLUSH_CYCLES(FLUSH)
`ifdef TRAP_CTRL_WATCHDOG_EN
    ,
    .WDT_CYCLES(8)
`endif
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .exc_valid_i   (exc_valid),
    .exc_target_i  (exc_target),
    .wb_valid_i    (wb_valid),
    .xint_meip_i   (meip),
    .xint_mtip_i   (mtip),
    .xint_msip_i   (msip),
    .mie_i         (mie),
    .mstatus_mie_i (mstatus_mie),
    .fetch_ack_i   (fetch_ack),
    .int_take_o    (int_take),
    .int_cause_o   (int_cause),
    .flush_o       (flush),
    .stall_o       (stall),
    .pc_redirect_o (redirect),
    .pc_target_o   (target),
`ifdef TRAP_CTRL_WATCHDOG_EN
    .wdt_fire_o    (wdt_fire),
`endif
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Commit a trap with the given target and walk the full flush/redirect/ack sequence.
  task automatic do_trap(input string tag, input logic [31:0] tgt);
    exc_valid  = 1'b1;
    exc_target = tgt;
    tick();
    exc_valid  = 1'b0;
    exc_target = 32'hDEAD_BEEF;
    for (int i = 0; i < FLUSH; i++) begin
      check({tag, "_flush"}, {31'd0, flush}, 32'd1);
      check({tag, "_flush_stall"}, {31'd0, stall}, 32'd1);
      check({tag, "_flush_noredir"}, {31'd0, redirect}, 32'd0);
      check({tag, "_flush_notake"}, {31'd0, int_take}, 32'd0);
      tick();
    end
    check({tag, "_redir"}, {31'd0, redirect}, 32'd1);
    check({tag, "_redir_noflush"}, {31'd0, flush}, 32'd0);
    check({tag, "_redir_target"}, target, tgt);
    check({tag, "_redir_stall"}, {31'd0, stall}, 32'd1);
    fetch_ack = 1'b1;  // ack during REDIRECT must be ignored
    tick();
    fetch_ack = 1'b0;
    check({tag, "_wait_redir"}, {31'd0, redirect}, 32'd0);
    check({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_wait_target"}, target, tgt);
    tick();
    check({tag, "_wait2_stall"}, {31'd0, stall}, 32'd1);
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_done_target"}, target, 32'd0);
  endtask

  initial begin
    rst = 1'b1; exc_valid = 1'b0; exc_target = 32'd0; wb_valid = 1'b0;
    meip = 1'b0; mtip = 1'b0; msip = 1'b0; mie = 32'd0; mstatus_mie = 1'b0;
    fetch_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redir", {31'd0, redirect}, 32'd0);
    check("rst_take", {31'd0, int_take}, 32'd0);
    check("rst_cause", int_cause, 32'd0);
    check("rst_target", target, 32'd0);
`ifdef TRAP_CTRL_WATCHDOG_EN
    check("rst_wdt", {31'd0, wdt_fire}, 32'd0);
`endif

    // Plain exception
    do_trap("exc", 32'h0000_0100);

    // Priority: all three pending, MEI wins, visible on the 3rd edge
    meip = 1'b1; mtip = 1'b1; msip = 1'b1; mie = 32'h888; mstatus_mie = 1'b1; wb_valid = 1'b1;
    tick();
    check("prio_e1", {31'd0, int_take}, 32'd0);
    tick();
    check("prio_e2", {31'd0, int_take}, 32'd0);
    tick();
    check("prio_take", {31'd0, int_take}, 32'd1);
    check("prio_cause", int_cause, 32'h8000_000B);
    check("prio_stall", {31'd0, stall}, 32'd1);
    meip = 1'b0; mtip = 1'b0; msip = 1'b0;  // dropping lines must not cancel
    tick();
    check("prio_pulse", {31'd0, int_take}, 32'd0);
    check("prio_hold_cause", int_cause, 32'h8000_000B);
    tick();
    tick();
    check("prio_pend_busy", {31'd0, busy}, 32'd1);
    check("prio_pend_noflush", {31'd0, flush}, 32'd0);
    do_trap("prio", 32'h0000_0200);

    // Masking by mstatus.MIE
    mtip = 1'b1; mie = 32'h080; mstatus_mie = 1'b0; wb_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mask_notake", {31'd0, int_take}, 32'd0);
    end
    mstatus_mie = 1'b1;
    tick();
    check("mask_take", {31'd0, int_take}, 32'd1);
    check("mask_cause", int_cause, 32'h8000_0007);
    mtip = 1'b0; mstatus_mie = 1'b0;
    do_trap("mask", 32'h0000_0180);

    // Exception beats an eligible interrupt; interrupt taken after return
    msip = 1'b1; mie = 32'h008; mstatus_mie = 1'b1; wb_valid = 1'b0;
    tick(); tick(); tick();
    wb_valid = 1'b1;
    do_trap("simul", 32'h0000_0300);
    tick();
    check("simul_late_take", {31'd0, int_take}, 32'd1);
    check("simul_late_cause", int_cause, 32'h8000_0003);
    msip = 1'b0; mstatus_mie = 1'b0; wb_valid = 1'b0;
    do_trap("simul_clr", 32'h0000_0340);

    // Reset during the 2nd flush cycle
    exc_valid = 1'b1; exc_target = 32'h0000_0400;
    tick();
    exc_valid = 1'b0;
    tick();
    check("rstf_flush2", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstf_busy", {31'd0, busy}, 32'd0);
    check("rstf_flush", {31'd0, flush}, 32'd0);
    check("rstf_stall", {31'd0, stall}, 32'd0);
    check("rstf_target", target, 32'd0);
    check("rstf_cause", int_cause, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstf_noredir", {31'd0, redirect}, 32'd0);
      check("rstf_idle", {31'd0, busy}, 32'd0);
    end

`ifdef TRAP_CTRL_WATCHDOG_EN
    // Watchdog: no ack, redirect repeats every 8 WAIT_ACK cycles
    exc_valid = 1'b1; exc_target = 32'h0000_0500;
    tick();
    exc_valid = 1'b0;
    for (int i = 0; i < FLUSH; i++) tick();
    check("wdt_redir0", {31'd0, redirect}, 32'd1);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 8; j++) begin
        tick();
        check("wdt_wait_noredir", {31'd0, redirect}, 32'd0);
        check("wdt_wait_nofire", {31'd0, wdt_fire}, 32'd0);
      end
      tick();
      check("wdt_fire", {31'd0, wdt_fire}, 32'd1);
      check("wdt_reredir", {31'd0, redirect}, 32'd1);
      check("wdt_target", target, 32'h0000_0500);
    end
    tick();
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    check("wdt_done_busy", {31'd0, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencing controller between the write-back stage and the fetch/pipeline control. It arbitrates synchronous exceptions/xRET against pending machine interrupts and requests interrupt commits from write-back. It sequences trap entry/exit: multi-cycle pipeline flush, PC redirect to the CSR-supplied target, stall until fetch restarts. An optional watchdog re-issues the redirect if fetch never acknowledges.

Parameters:
FLUSH_CYCLES, 3, cycles flush_o is held (1..15)
WDT_CYCLES, 64, watchdog timeout in WAIT_ACK (optional feature only; 2..255)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
exc_valid_i  in  1  WB commits a trap/xRET this cycle (exception-taken from WB)
exc_target_i  in  32  redirect address (mtvec or mepc) valid with exc_valid_i
wb_valid_i  in  1  a valid instruction occupies WB this cycle
xint_meip_i  in  1  external interrupt pending (async)
xint_mtip_i  in  1  timer interrupt pending (async)
xint_msip_i  in  1  software interrupt pending (async)
mie_i  in  32  CSR mie (bits 11, 7, 3 used)
mstatus_mie_i  in  1  global interrupt enable
fetch_ack_i  in  1  fetch accepted first instruction at redirected PC
int_take_o  out  1  request WB to commit interrupt on current instruction
int_cause_o  out  32  mcause value for int_take_o
flush_o  out  1  kill IF..MEM contents
stall_o  out  1  hold pipeline
pc_redirect_o  out  1  one-cycle PC load strobe
pc_target_o  out  32  PC load value
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; synchronizers, counters, captured target cleared. Reset in any state aborts the sequence next edge.
- xint_* pass 2-flop synchronizers; a pin change is visible to arbitration on the 3rd edge after assertion.
- Interrupt eligible = sync pending & matching mie bit & mstatus_mie_i. Priority MEI (cause 0x8000000B) > MSI (0x80000003) > MTI (0x80000007).
- States: IDLE, INT_PEND, FLUSH, REDIRECT, WAIT_ACK.
- IDLE:
  - exc_valid_i=1: capture exc_target_i -> FLUSH. Exceptions win over interrupts in the same cycle.
  - Else, if wb_valid_i and any eligible interrupt: register int_take_o=1 (single-cycle pulse) and int_cause_o -> INT_PEND.
- INT_PEND:
  - stall_o=1; int_cause_o held.
  - Wait for exc_valid_i; capture exc_target_i -> FLUSH. No timeout.
  - Interrupt lines dropping here do not cancel the request.
- FLUSH:
  - flush_o=1 and stall_o=1 for exactly FLUSH_CYCLES cycles (4-bit down-counter loaded on entry) -> REDIRECT.
- REDIRECT:
  - pc_redirect_o=1 for one cycle; pc_target_o=captured target; stall_o=1 -> WAIT_ACK.
- WAIT_ACK:
  - stall_o=1; pc_target_o held.
  - fetch_ack_i=1 -> IDLE; stall_o drops the same cycle the state reads IDLE.
  - fetch_ack_i arriving in REDIRECT's cycle is ignored.
- Outside IDLE/INT_PEND:
  - exc_valid_i ignored; no new interrupt accepted.
  - Pending interrupts stay visible and are re-evaluated on return to IDLE.
- pc_target_o is 0 in IDLE; otherwise the captured target. No alignment or arithmetic is performed on it.
- busy_o = (state != IDLE), registered with state.
- Back-to-back traps: the earliest re-entry is the cycle after returning to IDLE.

Optional Feature:
TRAP_CTRL_WATCHDOG_EN
- Defined:
  - 8-bit counter cleared on WAIT_ACK entry, increments each WAIT_ACK cycle.
  - Reaching WDT_CYCLES without fetch_ack_i: return to REDIRECT and re-pulse pc_redirect_o with the same target, counter reset.
  - Adds output wdt_fire_o (1 bit), a one-cycle pulse on each timeout, 0 at reset.
- Undefined: no counter, no wdt_fire_o port; WAIT_ACK waits indefinitely.

Test Plan:
- Exception: exc_valid_i=1, exc_target_i=0x00000100 in IDLE -> flush_o high 3 cycles; next cycle pc_redirect_o=1, pc_target_o=0x100; stall_o held until fetch_ack_i; busy_o falls the following cycle.
- Interrupt priority: meip, mtip, msip all high, mie=0x888, mstatus_mie_i=1, wb_valid_i=1 -> int_take_o pulse 3 edges later with int_cause_o=0x8000000B; exc_valid_i with target 0x200 -> full sequence to 0x200.
- Masking: mtip=1, mie=0x080, mstatus_mie_i=0 -> no int_take_o over 20 cycles; set mstatus_mie_i=1 -> int_take_o with cause 0x80000007.
- Simultaneous: exc_valid_i=1 (target 0x300) in the same cycle an interrupt is eligible -> no int_take_o; redirect to 0x300; interrupt taken after return to IDLE.
- Reset mid-FLUSH: assert rst_i for 1 cycle during the 2nd flush cycle -> next edge all outputs 0, state IDLE, no pc_redirect_o.
- Watchdog (TRAP_CTRL_WATCHDOG_EN, WDT_CYCLES=8): withhold fetch_ack_i -> wdt_fire_o and a second pc_redirect_o with the same target every 8 WAIT_ACK cycles; ack -> IDLE.
